// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types, widths and lane-mask helper for the load/store unit
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MW_BYTE = 2'd0,
        MW_HALF = 2'd1,
        MW_WORD = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } lsu_state_t;

    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    // Width code 3 is treated as a word access.
    function automatic logic [3:0] lane_mask(input logic [1:0] width);
        case (width)
            MW_BYTE: lane_mask = LANES_BYTE;
            MW_HALF: lane_mask = LANES_HALF;
            default: lane_mask = LANES_WORD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_load_store_unit_if.sv
// rtl/rv32i_load_store_unit_if.sv - request, RAM and response signals of the load/store unit
// master: execute stage + data RAM side; slave: the load/store unit.
interface rv32i_load_store_unit_if;

    logic                       req_valid;
    logic                       req_ready;
    logic                       req_we;
    logic [1:0]                 req_width;
    logic                       req_sign;
    logic [rv32i_pkg::XLEN-1:0] req_addr;
    logic [rv32i_pkg::XLEN-1:0] req_wdata;

    logic [rv32i_pkg::XLEN-1:0] d_addr;
    logic                       d_we;
    logic [3:0]                 d_be;
    logic [rv32i_pkg::XLEN-1:0] d_wdata;
    logic [rv32i_pkg::XLEN-1:0] d_rdata;

    logic                       rsp_valid;
    logic [rv32i_pkg::XLEN-1:0] rsp_rdata;
    logic                       rsp_fault;

    modport master (
        output req_valid, req_we, req_width, req_sign, req_addr, req_wdata, d_rdata,
        input  req_ready, d_addr, d_we, d_be, d_wdata, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_width, req_sign, req_addr, req_wdata, d_rdata,
        output req_ready, d_addr, d_we, d_be, d_wdata, rsp_valid, rsp_rdata, rsp_fault
    );

endinterface

// File: rtl/rv32i_lane_align.sv
// rtl/rv32i_lane_align.sv - combinational lane masks, store shifts and load extract/extend
// Ports:
//   i_width/i_sign/i_off      access width, load sign mode (0 sign-extend), byte offset
//   i_wdata                   right-justified store data
//   i_lo_word/i_hi_word       RAM words read for the LO and HI halves of the access
//   o_lo_be/o_hi_be           byte enables for the LO word and the spill into the HI word
//   o_lo_wdata/o_hi_wdata     lane-shifted store data for LO and HI words
//   o_misaligned              access crosses a word boundary
//   o_load_data               aligned, extended load result
module rv32i_lane_align
    import rv32i_pkg::*;
(
    input  logic [1:0]      i_width,
    input  logic            i_sign,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_lo_word,
    input  logic [XLEN-1:0] i_hi_word,
    output logic [3:0]      o_lo_be,
    output logic [3:0]      o_hi_be,
    output logic [XLEN-1:0] o_lo_wdata,
    output logic [XLEN-1:0] o_hi_wdata,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_load_data
);

    logic [7:0]        w_be_wide;
    logic [2*XLEN-1:0] w_wdata_wide;
    logic [XLEN-1:0]   w_rdata_shift;
    logic [4:0]        w_bit_shift;

    assign w_bit_shift  = {i_off, 3'b000};

    // Shift across an 8-lane / 64-bit window: the upper half is what spills into HI.
    assign w_be_wide    = {4'b0000, lane_mask(i_width)} << i_off;
    assign w_wdata_wide = {{XLEN{1'b0}}, i_wdata} << w_bit_shift;
    assign w_rdata_shift = XLEN'({i_hi_word, i_lo_word} >> w_bit_shift);

    assign o_lo_be    = w_be_wide[3:0];
    assign o_hi_be    = w_be_wide[7:4];
    assign o_lo_wdata = w_wdata_wide[XLEN-1:0];
    assign o_hi_wdata = w_wdata_wide[2*XLEN-1:XLEN];

    always_comb begin
        o_misaligned = 1'b0;
        o_load_data  = w_rdata_shift;
        case (i_width)
            MW_BYTE: begin
                o_load_data = {{24{~i_sign & w_rdata_shift[7]}}, w_rdata_shift[7:0]};
            end
            MW_HALF: begin
                o_misaligned = (i_off == 2'd3);
                o_load_data  = {{16{~i_sign & w_rdata_shift[15]}}, w_rdata_shift[15:0]};
            end
            default: begin
                o_misaligned = (i_off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/rv32i_load_store_unit.sv
// rtl/rv32i_load_store_unit.sv - load/store unit between execute and a 1-cycle-latency data RAM
// Ports:
//   i_clk     clock, all state on posedge
//   i_reset   asynchronous, active-high reset
//   io_lsu    request (req_*), RAM (d_*) and response (rsp_*) signals
// SPLIT_EN=1 splits word-crossing accesses into LO/HI RAM accesses; 0 rejects them with rsp_fault.
module rv32i_load_store_unit
    import rv32i_pkg::*;
#(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    rv32i_load_store_unit_if.slave  io_lsu
);

    lsu_state_t      r_state;
    logic            r_we;
    logic [1:0]      r_width;
    logic            r_sign;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic            r_fault;
    logic [XLEN-1:0] r_lo_buf;
    logic [XLEN-1:0] r_d_addr;
    logic            r_d_we;
    logic [3:0]      r_d_be;
    logic [XLEN-1:0] r_d_wdata;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_fault;

    logic            w_idle;
    logic [1:0]      w_width;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_lo_word;
    logic [XLEN-1:0] w_hi_word;
    logic [3:0]      w_lo_be;
    logic [3:0]      w_hi_be;
    logic [XLEN-1:0] w_lo_wdata;
    logic [XLEN-1:0] w_hi_wdata;
    logic            w_misaligned;
    logic [XLEN-1:0] w_load_data;

    assign w_idle = (r_state == IDLE);

    // In IDLE the aligner sees the incoming request so the LO bus values can be
    // registered at the accept edge; afterwards it works from the latched copy.
    assign w_width = w_idle ? io_lsu.req_width : r_width;
    assign w_addr  = w_idle ? io_lsu.req_addr  : r_addr;
    assign w_wdata = w_idle ? io_lsu.req_wdata : r_wdata;

    // In FIN, d_rdata is the HI word for a split access and the only word otherwise.
    assign w_lo_word = w_misaligned ? r_lo_buf : io_lsu.d_rdata;
    assign w_hi_word = w_misaligned ? io_lsu.d_rdata : {XLEN{1'b0}};

    rv32i_lane_align u_align (
        .i_width      (w_width),
        .i_sign       (r_sign),
        .i_off        (w_addr[1:0]),
        .i_wdata      (w_wdata),
        .i_lo_word    (w_lo_word),
        .i_hi_word    (w_hi_word),
        .o_lo_be      (w_lo_be),
        .o_hi_be      (w_hi_be),
        .o_lo_wdata   (w_lo_wdata),
        .o_hi_wdata   (w_hi_wdata),
        .o_misaligned (w_misaligned),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_width     <= 2'b00;
            r_sign      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_lo_buf    <= '0;
            r_d_addr    <= '0;
            r_d_we      <= 1'b0;
            r_d_be      <= 4'b0000;
            r_d_wdata   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_lsu.req_valid) begin
                        r_we    <= io_lsu.req_we;
                        r_width <= io_lsu.req_width;
                        r_sign  <= io_lsu.req_sign;
                        r_addr  <= io_lsu.req_addr;
                        r_wdata <= io_lsu.req_wdata;
                        if (w_misaligned && !SPLIT_EN) begin
                            r_fault <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_fault   <= 1'b0;
                            r_d_addr  <= {io_lsu.req_addr[XLEN-1:2], 2'b00};
                            r_d_be    <= w_lo_be;
                            r_d_we    <= io_lsu.req_we;
                            r_d_wdata <= w_lo_wdata;
                            r_state   <= LO;
                        end
                    end
                end
                LO: begin
                    if (w_misaligned) begin
                        r_d_addr  <= r_d_addr + XLEN'(4);
                        r_d_be    <= w_hi_be;
                        r_d_wdata <= w_hi_wdata;
                        r_state   <= HI;
                    end else begin
                        r_d_we  <= 1'b0;
                        r_d_be  <= 4'b0000;
                        r_state <= FIN;
                    end
                end
                HI: begin
                    r_lo_buf <= io_lsu.d_rdata;
                    r_d_we   <= 1'b0;
                    r_d_be   <= 4'b0000;
                    r_state  <= FIN;
                end
                FIN: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_fault <= r_fault;
                    r_rsp_rdata <= (r_we || r_fault) ? {XLEN{1'b0}} : w_load_data;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_lsu.req_ready = w_idle;
    assign io_lsu.d_addr    = r_d_addr;
    assign io_lsu.d_we      = r_d_we;
    assign io_lsu.d_be      = r_d_be;
    assign io_lsu.d_wdata   = r_d_wdata;
    assign io_lsu.rsp_valid = r_rsp_valid;
    assign io_lsu.rsp_rdata = r_rsp_rdata;
    assign io_lsu.rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// tb/tb_rv32i_load_store_unit.sv - self-checking bench for rv32i_load_store_unit
module tb_rv32i_load_store_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel_b;
    logic        t_valid, t_we, t_sign;
    logic [1:0]  t_width;
    logic [31:0] t_addr, t_wdata;

    rv32i_load_store_unit_if bus_a ();
    rv32i_load_store_unit_if bus_b ();

    rv32i_load_store_unit #(.SPLIT_EN(1'b1)) dut_a (.i_clk(clk), .i_reset(rst), .io_lsu(bus_a));
    rv32i_load_store_unit #(.SPLIT_EN(1'b0)) dut_b (.i_clk(clk), .i_reset(rst), .io_lsu(bus_b));

    assign bus_a.req_valid = t_valid & ~sel_b;
    assign bus_b.req_valid = t_valid & sel_b;
    assign bus_a.req_we    = t_we;
    assign bus_b.req_we    = t_we;
    assign bus_a.req_width = t_width;
    assign bus_b.req_width = t_width;
    assign bus_a.req_sign  = t_sign;
    assign bus_b.req_sign  = t_sign;
    assign bus_a.req_addr  = t_addr;
    assign bus_b.req_addr  = t_addr;
    assign bus_a.req_wdata = t_wdata;
    assign bus_b.req_wdata = t_wdata;

    logic        m_ready, m_d_we, m_rsp_valid, m_rsp_fault;
    logic [3:0]  m_d_be;
    logic [31:0] m_d_addr, m_d_wdata, m_rsp_rdata;
    assign m_ready     = sel_b ? bus_b.req_ready : bus_a.req_ready;
    assign m_d_we      = sel_b ? bus_b.d_we      : bus_a.d_we;
    assign m_d_be      = sel_b ? bus_b.d_be      : bus_a.d_be;
    assign m_d_addr    = sel_b ? bus_b.d_addr    : bus_a.d_addr;
    assign m_d_wdata   = sel_b ? bus_b.d_wdata   : bus_a.d_wdata;
    assign m_rsp_valid = sel_b ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign m_rsp_rdata = sel_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    assign m_rsp_fault = sel_b ? bus_b.rsp_fault : bus_a.rsp_fault;

    // Data RAMs: word array with byte enables, read data one cycle after address.
    logic [31:0] ram_a [int unsigned];
    logic [31:0] ram_b [int unsigned];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin : ram_a_p
        int unsigned k;
        logic [31:0] w;
        k = {2'b00, bus_a.d_addr[31:2]};
        w = ram_a.exists(k) ? ram_a[k] : 32'h0;
        bus_a.d_rdata <= w;
        if (bus_a.d_we) ram_a[k] = merge(w, bus_a.d_wdata, bus_a.d_be);
    end

    always @(posedge clk) begin : ram_b_p
        int unsigned k;
        logic [31:0] w;
        k = {2'b00, bus_b.d_addr[31:2]};
        w = ram_b.exists(k) ? ram_b[k] : 32'h0;
        bus_b.d_rdata <= w;
        if (bus_b.d_we) ram_b[k] = merge(w, bus_b.d_wdata, bus_b.d_be);
    end

    // Reference model: flat byte-addressed memory, little-endian, addresses wrap at 2^32.
    logic [7:0] ref_mem [logic [31:0]];

    function automatic int nbytes(input logic [1:0] width);
        return (width == 2'd0) ? 1 : (width == 2'd1) ? 2 : 4;
    endfunction

    function automatic void ref_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] width);
        for (int i = 0; i < nbytes(width); i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] width, input logic sign);
        int n = nbytes(width);
        logic [31:0] v = 32'h0;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            v[8*i +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        end
        if (!sign && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"},     32'(m_ready),     32'd1);
        chk({tag, "_d_we"},      32'(m_d_we),      32'd0);
        chk({tag, "_d_be"},      32'(m_d_be),      32'd0);
        chk({tag, "_d_addr"},    m_d_addr,         32'd0);
        chk({tag, "_d_wdata"},   m_d_wdata,        32'd0);
        chk({tag, "_rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, m_rsp_rdata,      32'd0);
        chk({tag, "_rsp_fault"}, 32'(m_rsp_fault), 32'd0);
    endtask

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        logic        fault;
        logic [31:0] lo_addr, hi_addr, lo_wd, hi_wd;
        logic [3:0]  lo_be, hi_be;
        logic        lo_we, hi_we;
        logic        bus_act;
    } obs_t;

    // One access; lat is the cycle of rsp_valid counting the accept cycle as 0 (0 = never seen).
    task automatic access(input logic b, input logic we, input logic [1:0] width, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
        o.rdata = 32'h0; o.lat = 0; o.fault = 1'b0; o.bus_act = 1'b0;
        o.lo_addr = 32'h0; o.hi_addr = 32'h0; o.lo_wd = 32'h0; o.hi_wd = 32'h0;
        o.lo_be = 4'h0; o.hi_be = 4'h0; o.lo_we = 1'b0; o.hi_we = 1'b0;
        @(negedge clk);
        sel_b = b; t_we = we; t_width = width; t_sign = sign; t_addr = addr; t_wdata = wdata;
        t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (m_d_be != 4'h0 || m_d_we) o.bus_act = 1'b1;
            if (k == 1) begin o.lo_addr = m_d_addr; o.lo_be = m_d_be; o.lo_we = m_d_we; o.lo_wd = m_d_wdata; end
            if (k == 2) begin o.hi_addr = m_d_addr; o.hi_be = m_d_be; o.hi_we = m_d_we; o.hi_wd = m_d_wdata; end
            if (m_rsp_valid) begin
                o.lat = k; o.rdata = m_rsp_rdata; o.fault = m_rsp_fault;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr, wdata, exp_rdata;
        int          exp_lat;
        logic [31:0] lo_addr;
        logic [3:0]  lo_be;
        logic [31:0] lo_wd, hi_addr;
        logic [3:0]  hi_be;
        logic [31:0] hi_wd;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        obs_t o;
        vec_t v;
        logic        r_we, r_sign;
        logic [1:0]  r_width;
        logic [31:0] r_addr, r_wdata, exp_rd;
        int          exp_lat, seen;

        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h50,       32'h80,       32'h0,        3, 32'h50,       4'h1, 32'h80,       32'h0,  4'h0, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h50,       32'h0,        32'hFFFFFF80, 3, 32'h50,       4'h1, 32'h0,        32'h0,  4'h0, 32'h0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'h50,       32'h0,        32'h80,       3, 32'h50,       4'h1, 32'h0,        32'h0,  4'h0, 32'h0};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h0C,       32'h12345678, 32'h0,        3, 32'h0C,       4'hF, 32'h12345678, 32'h0,  4'h0, 32'h0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 32'h0E,       32'h0,        32'h1234,     3, 32'h0C,       4'hC, 32'h0,        32'h0,  4'h0, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h0F,       32'h0,        32'h12,       3, 32'h0C,       4'h8, 32'h0,        32'h0,  4'h0, 32'h0};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h51,       32'hAABBCCDD, 32'h0,        4, 32'h50,       4'hE, 32'hBBCCDD00, 32'h54, 4'h1, 32'hAA};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h51,       32'h0,        32'hAABBCCDD, 4, 32'h50,       4'hE, 32'h0,        32'h54, 4'h1, 32'h0};
        vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'hBEEF,     32'h0,        4, 32'hFFFFFFFC, 4'h8, 32'hEF000000, 32'h0,  4'h1, 32'hBE};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        32'hFFFFBEEF, 4, 32'hFFFFFFFC, 4'h8, 32'h0,        32'h0,  4'h1, 32'h0};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0C,       32'h0,        32'h12345678, 3, 32'h0C,       4'hF, 32'h0,        32'h0,  4'h0, 32'h0};
        vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0D,       32'h0,        32'h3456,     3, 32'h0C,       4'h6, 32'h0,        32'h0,  4'h0, 32'h0};

        sel_b = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_sign = 1'b0; t_width = 2'd0;
        t_addr = 32'h0; t_wdata = 32'h0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2 chk_reset_values("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Directed table on the splitting instance.
        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            access(1'b0, v.we, v.width, v.sign, v.addr, v.wdata, o);
            if (v.we) ref_store(v.addr, v.wdata, v.width);
            chk($sformatf("v%0d_rdata", i),   o.rdata,       v.exp_rdata);
            chk($sformatf("v%0d_latency", i), 32'(o.lat),    32'(v.exp_lat));
            chk($sformatf("v%0d_fault", i),   32'(o.fault),  32'd0);
            chk($sformatf("v%0d_lo_addr", i), o.lo_addr,     v.lo_addr);
            chk($sformatf("v%0d_lo_be", i),   32'(o.lo_be),  32'(v.lo_be));
            chk($sformatf("v%0d_lo_we", i),   32'(o.lo_we),  32'(v.we));
            if (v.we) chk($sformatf("v%0d_lo_wdata", i), o.lo_wd, v.lo_wd);
            if (v.exp_lat == 4) begin
                chk($sformatf("v%0d_hi_addr", i), o.hi_addr,    v.hi_addr);
                chk($sformatf("v%0d_hi_be", i),   32'(o.hi_be), 32'(v.hi_be));
                chk($sformatf("v%0d_hi_we", i),   32'(o.hi_we), 32'(v.we));
                if (v.we) chk($sformatf("v%0d_hi_wdata", i), o.hi_wd, v.hi_wd);
            end
        end

        // Random accesses against the byte-level reference.
        for (int i = 0; i < 200; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_width = 2'($urandom_range(0, 3));
            r_sign  = 1'($urandom_range(0, 1));
            r_addr  = 32'h200 + $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) r_addr = 32'hFFFFFFF8 + $urandom_range(0, 7);
            r_wdata = $urandom;
            exp_rd  = r_we ? 32'h0 : ref_load(r_addr, r_width, r_sign);
            exp_lat = (int'(r_addr[1:0]) + nbytes(r_width) > 4) ? 4 : 3;
            access(1'b0, r_we, r_width, r_sign, r_addr, r_wdata, o);
            if (r_we) ref_store(r_addr, r_wdata, r_width);
            chk($sformatf("rnd%0d_rdata @%08h w%0d", i, r_addr, r_width), o.rdata, exp_rd);
            chk($sformatf("rnd%0d_latency", i), 32'(o.lat), 32'(exp_lat));
        end

        // Back-to-back aligned loads with req_valid held high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel_b = 1'b0; t_we = 1'b0; t_width = 2'd2; t_sign = 1'b0; t_addr = 32'h0C; t_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), 32'(m_ready), 32'(c % 3 == 0));
            chk($sformatf("b2b_rsp_valid_c%0d", c), 32'(m_rsp_valid), 32'(c >= 3 && c % 3 == 0));
            if (c >= 3 && c % 3 == 0) chk($sformatf("b2b_rdata_c%0d", c), m_rsp_rdata, 32'h12345678);
            @(negedge clk);
        end
        t_valid = 1'b0;
        repeat (4) @(posedge clk);

        // Reset asserted during HI of a split load.
        @(negedge clk);
        sel_b = 1'b0; t_we = 1'b0; t_width = 2'd2; t_addr = 32'h51; t_valid = 1'b1;
        @(posedge clk); #1;
        t_valid = 1'b0;
        @(posedge clk); #2;
        chk("midrst_hi_addr", m_d_addr, 32'h54);
        chk("midrst_hi_be", 32'(m_d_be), 32'h1);
        rst = 1'b1;
        #1 chk_reset_values("midrst");
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (m_rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);

        // Non-splitting instance: misaligned rejected, aligned works.
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, o);
        chk("nosplit_ldw_done",  32'(o.lat > 0), 32'd1);
        chk("nosplit_ldw_fault", 32'(o.fault),   32'd1);
        chk("nosplit_ldw_rdata", o.rdata,        32'h0);
        chk("nosplit_ldw_bus",   32'(o.bus_act), 32'd0);
        access(1'b1, 1'b1, 2'd1, 1'b0, 32'h43, 32'hFFFF, o);
        chk("nosplit_sth_fault", 32'(o.fault),   32'd1);
        chk("nosplit_sth_bus",   32'(o.bus_act), 32'd0);
        access(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, o);
        chk("nosplit_stw_fault", 32'(o.fault), 32'd0);
        chk("nosplit_stw_lat",   32'(o.lat),   32'd3);
        access(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, o);
        chk("nosplit_ldw_rdata_ok", o.rdata, 32'hCAFEF00D);
        access(1'b1, 1'b0, 2'd1, 1'b0, 32'h41, 32'h0, o);
        chk("nosplit_ldh1_rdata", o.rdata,      32'hFFFFFEF0);
        chk("nosplit_ldh1_fault", 32'(o.fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
